// File: rtl/pipe_pkg.sv
// Shared definitions for the 16-bit five-stage pipeline.
// Contents:
//   word_t             16-bit machine word
//   DEFAULT_NOP_INSTR  bubble encoding (opcode 00001)
//   DEFAULT_HALT_OP    opcode value that stops instruction fetch
//   opcode_of()        returns the opcode field, instr[15:11]
//   fetch_state_e      fetch FSM states
package pipe_pkg;

  typedef logic [15:0] word_t;

  localparam word_t      DEFAULT_NOP_INSTR = 16'h0800;
  localparam logic [4:0] DEFAULT_HALT_OP   = 5'b00000;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_HALTED
  } fetch_state_e;

  function automatic logic [4:0] opcode_of(input word_t instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Priority on each edge: flush > hold > load.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   flush_i       load a bubble regardless of write_i
//   write_i       0 = hold every field
//   fetch_ok_i    instr_i carries a real fetched word this cycle
//   instr_i       fetched instruction
//   pcplus2_i     PC+2 of instr_i
//   instr_o       registered instruction (bubble when invalid)
//   pcplus2_o     registered PC+2 (zero for bubbles)
//   valid_o       1 = instr_o is a real fetched instruction
module if_id_reg
  import pipe_pkg::*;
#(
  parameter word_t NOP_WORD = DEFAULT_NOP_INSTR
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  flush_i,
  input  logic  write_i,
  input  logic  fetch_ok_i,
  input  word_t instr_i,
  input  word_t pcplus2_i,
  output word_t instr_o,
  output word_t pcplus2_o,
  output logic  valid_o
);

  word_t instr_q, instr_d;
  word_t pcplus2_q, pcplus2_d;
  logic  valid_q, valid_d;

  // NOTE: every signal gets a default at the top of always_comb so that no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    instr_d   = instr_q;
    pcplus2_d = pcplus2_q;
    valid_d   = valid_q;
    if (flush_i || (write_i && !fetch_ok_i)) begin
      instr_d   = NOP_WORD;
      pcplus2_d = '0;
      valid_d   = 1'b0;
    end else if (write_i) begin
      instr_d   = instr_i;
      pcplus2_d = pcplus2_i;
      valid_d   = 1'b1;
    end
  end

  // NOTE: state elements use non-blocking assignments so all flops sample
  // their inputs from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q   <= NOP_WORD;
      pcplus2_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pcplus2_q <= pcplus2_d;
      valid_q   <= valid_d;
    end
  end

  assign instr_o   = instr_q;
  assign pcplus2_o = pcplus2_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, single-outstanding instruction-memory request, redirect
// handling, HALT detection and the IF/ID register.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   PCWrite         0 = hold PC (redirects ignore it)
//   IF_ID_Write     0 = hold IF/ID
//   IF_ID_Flush     1 = load a bubble into IF/ID
//   redir_valid     redirect from branch resolution; redir_pc is the target
//   imem_req        fetch request (low only while halted)
//   imem_addr       fetch address, always the current PC
//   imem_rdy        imem_data is valid for imem_addr this cycle
//   imem_data       fetched instruction
//   IF_ID_instr, IF_ID_pcplus2, IF_ID_valid   IF/ID register contents
//   halted          fetch stopped on a HALT
//   mem_stall_cnt   saturating count of cycles with imem_req=1, imem_rdy=0
module fetch_stage
  import pipe_pkg::*;
#(
  parameter word_t      RESET_PC  = 16'h0000,
  parameter word_t      NOP_INSTR = DEFAULT_NOP_INSTR,
  parameter logic [4:0] HALT_OP   = DEFAULT_HALT_OP
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  PCWrite,
  input  logic  IF_ID_Write,
  input  logic  IF_ID_Flush,
  input  logic  redir_valid,
  input  word_t redir_pc,
  output logic  imem_req,
  output word_t imem_addr,
  input  logic  imem_rdy,
  input  word_t imem_data,
  output word_t IF_ID_instr,
  output word_t IF_ID_pcplus2,
  output logic  IF_ID_valid,
  output logic  halted,
  output word_t mem_stall_cnt
);

  fetch_state_e state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        stall_cnt_q, stall_cnt_d;
  logic         halted_q;
  logic         fetch_ok;
  word_t        pc_plus2;

  assign pc_plus2 = pc_q + 16'd2;  // wraps FFFE -> 0000
  assign imem_req = (state_q != ST_HALTED);
  assign imem_addr = pc_q;
  assign fetch_ok = imem_req && imem_rdy;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    stall_cnt_d = stall_cnt_q;

    if (imem_req && !imem_rdy && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;

    if (redir_valid) begin
      pc_d    = redir_pc;
      state_d = ST_RUN;
    end else if (state_q != ST_HALTED) begin
      if (imem_rdy) begin
        // A HALT only stops fetch when the PC is allowed to move; a stalled
        // HALT is simply refetched later.
        if ((opcode_of(imem_data) == HALT_OP) && PCWrite) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_RUN;
          if (PCWrite) pc_d = pc_plus2;
        end
      end else begin
        state_d = ST_MEM_WAIT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      stall_cnt_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
      halted_q    <= (state_d == ST_HALTED);
    end
  end

  assign halted        = halted_q;
  assign mem_stall_cnt = stall_cnt_q;

  // A redirect squashes whatever is being fetched, so it flushes IF/ID too.
  if_id_reg #(
    .NOP_WORD (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (redir_valid || IF_ID_Flush),
    .write_i    (IF_ID_Write),
    .fetch_ok_i (fetch_ok),
    .instr_i    (imem_data),
    .pcplus2_i  (pc_plus2),
    .instr_o    (IF_ID_instr),
    .pcplus2_o  (IF_ID_pcplus2),
    .valid_o    (IF_ID_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by
// randomized traffic, checked through an expectation queue and monitor.
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCWrite = 1'b1, IF_ID_Write = 1'b1, IF_ID_Flush = 1'b0;
  logic        redir_valid = 1'b0;
  logic [15:0] redir_pc = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy = 1'b0;
  logic [15:0] imem_data = '0;
  logic [15:0] IF_ID_instr, IF_ID_pcplus2;
  logic        IF_ID_valid, halted;
  logic [15:0] mem_stall_cnt;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .PCWrite       (PCWrite),
    .IF_ID_Write   (IF_ID_Write),
    .IF_ID_Flush   (IF_ID_Flush),
    .redir_valid   (redir_valid),
    .redir_pc      (redir_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdy      (imem_rdy),
    .imem_data     (imem_data),
    .IF_ID_instr   (IF_ID_instr),
    .IF_ID_pcplus2 (IF_ID_pcplus2),
    .IF_ID_valid   (IF_ID_valid),
    .halted        (halted),
    .mem_stall_cnt (mem_stall_cnt)
  );

  typedef struct {
    logic [15:0] pc;
    logic        req;
    logic        halted;
    logic [15:0] instr;
    logic [15:0] pcp2;
    logic        valid;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: architectural view of the fetch unit.
  logic [15:0] m_pc;
  bit          m_halted;
  logic [15:0] m_instr, m_pcp2;
  bit          m_valid;
  int          m_cnt;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_halted = 0; m_instr = NOP; m_pcp2 = 16'h0000;
    m_valid = 0; m_cnt = 0;
  endtask

  // Synthetic program memory: fixed word per address, with occasional HALTs.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    int w = int'(a) >> 1;
    logic [4:0] opc;
    opc = (w % 23 == 5) ? 5'd0 : 5'(1 + (w % 30));
    return {opc, a[10:0]};
  endfunction

  // Drives one cycle's inputs (called just after a falling edge), advances
  // the model across the next rising edge and queues what should be seen.
  task automatic step(input bit pcw, input bit ifw, input bit fl, input bit rv,
                      input logic [15:0] rpc, input bit rdy, input logic [15:0] data);
    exp_t e;
    bit   fetched;
    PCWrite = pcw; IF_ID_Write = ifw; IF_ID_Flush = fl;
    redir_valid = rv; redir_pc = rpc; imem_rdy = rdy; imem_data = data;

    if (!m_halted && !rdy && m_cnt < 65535) m_cnt++;
    fetched = !m_halted && rdy;
    if (rv) begin
      m_instr = NOP; m_valid = 0;
      m_pc = rpc; m_halted = 0;
    end else begin
      if (fl) begin
        m_instr = NOP; m_valid = 0;
      end else if (ifw) begin
        if (fetched) begin
          m_instr = data; m_pcp2 = m_pc + 16'd2; m_valid = 1;
        end else begin
          m_instr = NOP; m_valid = 0;
        end
      end
      if (fetched && pcw) begin
        if (data[15:11] == 5'b00000) m_halted = 1;
        else m_pc = m_pc + 16'd2;
      end
    end
    e.pc = m_pc; e.req = !m_halted; e.halted = m_halted; e.instr = m_instr;
    e.pcp2 = m_pcp2; e.valid = m_valid; e.cnt = 16'(m_cnt);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic fetch_cur();
    step(1, 1, 0, 0, 16'h0, 1, mem_word(m_pc));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"},   imem_addr, 16'h0000);
    check({tag, "_req"},    16'(imem_req), 16'd1);
    check({tag, "_instr"},  IF_ID_instr, NOP);
    check({tag, "_pcp2"},   IF_ID_pcplus2, 16'h0000);
    check({tag, "_valid"},  16'(IF_ID_valid), 16'd0);
    check({tag, "_halted"}, 16'(halted), 16'd0);
    check({tag, "_cnt"},    mem_stall_cnt, 16'h0000);
  endtask

  // Monitor: compares DUT outputs one time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("imem_addr", imem_addr, e.pc);
        check("imem_req", 16'(imem_req), 16'(e.req));
        check("halted", 16'(halted), 16'(e.halted));
        check("IF_ID_instr", IF_ID_instr, e.instr);
        check("IF_ID_valid", 16'(IF_ID_valid), 16'(e.valid));
        if (e.valid) check("IF_ID_pcplus2", IF_ID_pcplus2, e.pcp2);
        check("mem_stall_cnt", mem_stall_cnt, e.cnt);
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_values("reset");

    // Sequential fetch, then a 3-cycle memory stall at PC 4.
    step(1, 1, 0, 0, 16'h0, 1, 16'h4001);
    step(1, 1, 0, 0, 16'h0, 1, 16'h4002);
    repeat (3) step(1, 1, 0, 0, 16'h0, 0, 16'h0000);
    step(1, 1, 0, 0, 16'h0, 1, 16'h4003);

    // Freeze, then flush with the PC still held.
    repeat (2) step(0, 0, 0, 0, 16'h0, 1, mem_word(m_pc));
    step(0, 1, 1, 0, 16'h0, 1, mem_word(m_pc));

    // Redirect out of MEM_WAIT while IF/ID writes are blocked.
    step(1, 1, 0, 0, 16'h0, 0, 16'h0000);
    step(1, 0, 0, 1, 16'h0100, 0, 16'h0000);
    fetch_cur();

    // HALT at 0x0010, sit halted, resume at 0x0020.
    step(1, 1, 0, 1, 16'h0010, 0, 16'h0000);
    step(1, 1, 0, 0, 16'h0, 1, 16'h0000);
    repeat (2) step(1, 1, 0, 0, 16'h0, 1, 16'h1234);
    step(1, 1, 0, 1, 16'h0020, 0, 16'h0000);
    fetch_cur();

    // PC wrap at the top of memory.
    step(1, 1, 0, 1, 16'hFFFE, 1, 16'h0000);
    step(1, 1, 0, 0, 16'h0, 1, 16'h4444);
    fetch_cur();

    // Asynchronous reset in the middle of MEM_WAIT.
    step(1, 1, 0, 0, 16'h0, 0, 16'h0000);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      bit pcw, ifw, fl, rv, rdy;
      logic [15:0] rpc;
      pcw = ($urandom % 8) != 0;
      ifw = ($urandom % 8) != 0;
      fl  = ($urandom % 10) == 0;
      rv  = ($urandom % 20) == 0;
      rdy = ($urandom % 4) != 0;
      rpc = 16'($urandom) & 16'hFFFE;
      step(pcw, ifw, fl, rv, rpc, rdy, rdy ? mem_word(m_pc) : 16'($urandom));
    end

    repeat (2) @(negedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
